// File: rtl/prince_sbox_layer_ctrl.sv
// Masked PRINCE inverse S-box layer sequencer.
// Feeds a 64-bit, 3-share state through a shared 16-bit FourSboxes datapath
// one group per cycle, tracks in-flight groups with a tag shift register that
// matches the datapath latency, and reassembles the shared result.
//
// Ports:
//   clk, rst_i                  clock, synchronous active-high reset
//   in_valid/in_ready/in_s1..3  state handshake from the round controller
//   out_valid/out_ready/out_s*  result handshake, out_err flags starvation
//   rnd_valid/rnd_ready/rnd_data  PRNG word stream (168 bits)
//   sbox_in1..3, sbox_r         datapath inputs (combinational, zero when idle)
//   sbox_out1..3                datapath outputs, SBOX_LAT cycles after input
module prince_sbox_layer_ctrl #(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_s1,
  input  logic [63:0]   in_s2,
  input  logic [63:0]   in_s3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_s1,
  output logic [63:0]   out_s2,
  output logic [63:0]   out_s3,
  output logic          out_err,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  input  logic [167:0]  rnd_data,
  output logic [15:0]   sbox_in1,
  output logic [15:0]   sbox_in2,
  output logic [15:0]   sbox_in3,
  output logic [167:0]  sbox_r,
  input  logic [15:0]   sbox_out1,
  input  logic [15:0]   sbox_out2,
  input  logic [15:0]   sbox_out3
);

  localparam int unsigned SW = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned IW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
  } tag_t;

  state_t        state_q, state_d;
  logic [63:0]   s1_q, s2_q, s3_q;
  logic [63:0]   r1_q, r2_q, r3_q;
  logic [IW-1:0] k_q;
  logic          err_q;
  logic          in_ready_q, out_valid_q, rnd_ready_q;
  tag_t          tag_q [SBOX_LAT];

  logic          accept_c, release_c, issue_c, starve_c;
  logic          tag_busy_c, tag_busy_nxt_c;
  tag_t          push_c;
  tag_t          cap_c;

  assign cap_c = tag_q[SBOX_LAT-1];

  // Next state, issue gating and datapath drive; datapath inputs are zero
  // whenever no group is issued so no stale share lingers on the wires.
  always_comb begin
    state_d        = state_q;
    accept_c       = 1'b0;
    release_c      = 1'b0;
    issue_c        = 1'b0;
    starve_c       = 1'b0;
    tag_busy_c     = 1'b0;
    tag_busy_nxt_c = 1'b0;
    push_c         = '0;
    sbox_in1       = '0;
    sbox_in2       = '0;
    sbox_in3       = '0;
    sbox_r         = '0;

    for (int unsigned i = 0; i < SBOX_LAT; i++) begin
      tag_busy_c = tag_busy_c | tag_q[i].valid;
    end

    issue_c      = (state_q == ISSUE) && rnd_valid;
    starve_c     = tag_busy_c && !rnd_valid;
    push_c.valid = issue_c;
    push_c.idx   = k_q;

    // Occupancy after this edge's shift, used for the registered rnd_ready.
    tag_busy_nxt_c = issue_c;
    for (int unsigned i = 0; i + 1 < SBOX_LAT; i++) begin
      tag_busy_nxt_c = tag_busy_nxt_c | tag_q[i].valid;
    end

    if (issue_c) begin
      sbox_in1 = s1_q[SW*32'(k_q) +: SW];
      sbox_in2 = s2_q[SW*32'(k_q) +: SW];
      sbox_in3 = s3_q[SW*32'(k_q) +: SW];
      sbox_r   = rnd_data;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_c && (k_q == IW'(NS - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!tag_busy_c) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, share/result storage and in-flight tag tracking.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rnd_ready_q <= 1'b0;
      for (int unsigned i = 0; i < SBOX_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
      rnd_ready_q <= (state_d == ISSUE) || tag_busy_nxt_c;

      tag_q[0] <= push_c;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      if (issue_c) begin
        k_q <= k_q + IW'(1);
      end
      if (starve_c) begin
        err_q <= 1'b1;
      end

      if (accept_c) begin
        s1_q  <= in_s1;
        s2_q  <= in_s2;
        s3_q  <= in_s3;
        k_q   <= '0;
        err_q <= 1'b0;
      end

      // Datapath output lines up with the oldest tag entry.
      if (cap_c.valid) begin
        r1_q[SW*32'(cap_c.idx) +: SW] <= sbox_out1;
        r2_q[SW*32'(cap_c.idx) +: SW] <= sbox_out2;
        r3_q[SW*32'(cap_c.idx) +: SW] <= sbox_out3;
      end

      if (release_c) begin
        s1_q <= '0;
        s2_q <= '0;
        s3_q <= '0;
        r1_q <= '0;
        r2_q <= '0;
        r3_q <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rnd_ready = rnd_ready_q;
  assign out_err   = err_q;
  assign out_s1    = r1_q;
  assign out_s2    = r2_q;
  assign out_s3    = r3_q;

endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Directed bench for prince_sbox_layer_ctrl with a behavioural 4-cycle
// masked inverse S-box datapath model.
module tb_prince_sbox_layer_ctrl;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_valid, in_ready;
  logic [63:0]   in_s1, in_s2, in_s3;
  logic          out_valid, out_ready, out_err;
  logic [63:0]   out_s1, out_s2, out_s3;
  logic          rnd_valid, rnd_ready;
  logic [167:0]  rnd_data;
  logic [15:0]   sbox_in1, sbox_in2, sbox_in3;
  logic [167:0]  sbox_r;
  logic [15:0]   sbox_out1, sbox_out2, sbox_out3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prince_sbox_layer_ctrl #(.SBOX_LAT(4)) dut (
    .clk(clk), .rst_i(rst_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3), .out_err(out_err),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3), .sbox_r(sbox_r),
    .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3)
  );

  function automatic logic [3:0] inv_nib(input logic [3:0] v);
    case (v)
      4'h0: inv_nib = 4'hB;  4'h1: inv_nib = 4'h7;  4'h2: inv_nib = 4'h3;  4'h3: inv_nib = 4'h2;
      4'h4: inv_nib = 4'hF;  4'h5: inv_nib = 4'hD;  4'h6: inv_nib = 4'h8;  4'h7: inv_nib = 4'h9;
      4'h8: inv_nib = 4'hA;  4'h9: inv_nib = 4'h6;  4'hA: inv_nib = 4'h4;  4'hB: inv_nib = 4'h0;
      4'hC: inv_nib = 4'h5;  4'hD: inv_nib = 4'hE;  4'hE: inv_nib = 4'hC;  default: inv_nib = 4'h1;
    endcase
  endfunction

  function automatic logic [63:0] inv64(input logic [63:0] v);
    for (int i = 0; i < 16; i++) inv64[4*i +: 4] = inv_nib(v[4*i +: 4]);
  endfunction

  // Datapath model: unmask, substitute, remask with randomness, 4-cycle latency.
  function automatic logic [47:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [167:0] r);
    logic [15:0] y, m1, m2;
    y = 16'(inv64({48'h0, a ^ b ^ c}));
    m1 = r[15:0];
    m2 = r[47:32] ^ r[167:152];
    model = {y ^ m1, m2, m1 ^ m2};
  endfunction

  logic [47:0] pipe [4];
  always @(posedge clk) begin
    pipe[0] <= model(sbox_in1, sbox_in2, sbox_in3, sbox_r);
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign {sbox_out1, sbox_out2, sbox_out3} = pipe[3];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [167:0] rnd();
    rnd = {8'($urandom()), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full state: accept in cycle 0, then issue/drain/hold and handshake.
  task automatic run_op(input string nm, input logic [63:0] x, input logic [63:0] a,
                        input logic [63:0] b, input logic [15:0] starve,
                        input logic [15:0] issue, input int out_cyc, input logic [63:0] exp_y,
                        input logic exp_err, input int hold, input logic after_rst);
    logic [63:0]  s3;
    logic [192:0] held;
    int k;
    s3 = x ^ a ^ b;
    k  = 0;
    go();
    rst_i = 1'b0; in_valid = 1'b1; in_s1 = a; in_s2 = b; in_s3 = s3;
    rnd_valid = !starve[0]; rnd_data = rnd(); out_ready = 1'b0;
    #2;
    chk({nm, " c0 in_ready"}, 256'(in_ready), 256'(1'b1));
    chk({nm, " c0 out_valid"}, 256'(out_valid), 256'(1'b0));
    chk({nm, " c0 out_s"}, 256'({out_s1, out_s2, out_s3}), '0);
    chk({nm, " c0 rnd_ready"}, 256'(rnd_ready), 256'(1'b0));
    chk({nm, " c0 sbox"}, 256'({sbox_in1, sbox_in2, sbox_in3, sbox_r}), '0);
    if (after_rst) chk({nm, " c0 out_err"}, 256'(out_err), 256'(1'b0));
    for (int c = 1; c <= out_cyc; c++) begin
      go();
      in_valid = 1'b0; in_s1 = ~a; in_s2 = ~b; in_s3 = ~s3;
      rnd_valid = !starve[c]; rnd_data = rnd();
      #2;
      if (issue[c]) begin
        chk($sformatf("%s c%0d sbox_issue", nm, c),
            256'({sbox_in1, sbox_in2, sbox_in3, sbox_r}),
            256'({a[16*k +: 16], b[16*k +: 16], s3[16*k +: 16], rnd_data}));
        k++;
      end else begin
        chk($sformatf("%s c%0d sbox_idle", nm, c),
            256'({sbox_in1, sbox_in2, sbox_in3, sbox_r}), '0);
      end
      chk($sformatf("%s c%0d in_ready", nm, c), 256'(in_ready), 256'(1'b0));
      chk($sformatf("%s c%0d out_valid", nm, c), 256'(out_valid), 256'(c == out_cyc));
      chk($sformatf("%s c%0d rnd_ready", nm, c), 256'(rnd_ready), 256'(c <= out_cyc - 2));
    end
    chk({nm, " result"}, 256'(out_s1 ^ out_s2 ^ out_s3), 256'(exp_y));
    chk({nm, " out_err"}, 256'(out_err), 256'(exp_err));
    held = {out_s1, out_s2, out_s3, out_err};
    for (int h = 0; h < hold; h++) begin
      go();
      out_ready = 1'b0; rnd_valid = 1'b1; rnd_data = rnd();
      #2;
      chk($sformatf("%s h%0d stable", nm, h), 256'({out_s1, out_s2, out_s3, out_err}), 256'(held));
      chk($sformatf("%s h%0d out_valid", nm, h), 256'(out_valid), 256'(1'b1));
      chk($sformatf("%s h%0d in_ready", nm, h), 256'(in_ready), 256'(1'b0));
      chk($sformatf("%s h%0d rnd_ready", nm, h), 256'(rnd_ready), 256'(1'b0));
      chk($sformatf("%s h%0d sbox", nm, h), 256'({sbox_in1, sbox_in2, sbox_in3, sbox_r}), '0);
    end
    go();
    out_ready = 1'b1;
    #2;
    chk({nm, " hs out_valid"}, 256'(out_valid), 256'(1'b1));
  endtask

  initial begin
    rst_i = 1'b1; in_valid = 1'b0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
    out_ready = 1'b0; rnd_valid = 1'b0; rnd_data = '0;
    go();
    go();
    go();
    #2;
    chk("reset in_ready", 256'(in_ready), 256'(1'b1));
    chk("reset out_valid", 256'(out_valid), 256'(1'b0));
    chk("reset rnd_ready", 256'(rnd_ready), 256'(1'b0));

    // Nominal: constant randomness, result against hand-computed constant.
    run_op("t1", 64'h0123456789ABCDEF, 64'hA5A5_1234_0F0F_9876, 64'h3C3C_DEAD_BEEF_0001,
           16'h0000, 16'h001E, 10, 64'hB732FD89A6405EC1, 1'b0, 0, 1'b1);
    // Randomness gap in cycles 2,3 while slice 0 in flight; output held 5 cycles.
    run_op("t2", 64'hFEDCBA9876543210, 64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF,
           16'h000C, 16'h0072, 12, inv64(64'hFEDCBA9876543210), 1'b1, 5, 1'b0);
    // Gap in cycle 1 only: nothing in flight, so no starvation flag.
    run_op("t3", 64'h5A5A_0F0F_C3C3_9696, 64'h1357_9BDF_2468_ACE0, 64'hFFFF_0000_FFFF_0000,
           16'h0002, 16'h003C, 11, inv64(64'h5A5A_0F0F_C3C3_9696), 1'b0, 0, 1'b0);

    // Abort: accept, run to cycle 6, reset there.
    go();
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; rnd_data = rnd();
    in_s1 = 64'hDEAD_BEEF_DEAD_BEEF; in_s2 = 64'h0BAD_F00D_0BAD_F00D; in_s3 = 64'h1234_5678_9ABC_DEF0;
    #2;
    chk("abort accept in_ready", 256'(in_ready), 256'(1'b1));
    for (int c = 1; c <= 5; c++) begin
      go();
      in_valid = 1'b0; rnd_valid = 1'b1; rnd_data = rnd();
    end
    go();
    rst_i = 1'b1;
    #2;
    chk("abort c6 out_valid", 256'(out_valid), 256'(1'b0));
    run_op("t4", 64'h0F1E2D3C4B5A6978, 64'h7777_8888_9999_AAAA, 64'h1111_2222_3333_4444,
           16'h0000, 16'h001E, 10, inv64(64'h0F1E2D3C4B5A6978), 1'b0, 0, 1'b1);
    // Back-to-back accept in the cycle after the handshake.
    run_op("t5", 64'h0000_0000_FFFF_FFFF, 64'hCAFE_BABE_FACE_B00C, 64'h0123_4567_89AB_CDEF,
           16'h0000, 16'h001E, 10, inv64(64'h0000_0000_FFFF_FFFF), 1'b0, 0, 1'b0);

    go();
    out_ready = 1'b0; in_valid = 1'b0;
    #2;
    chk("final in_ready", 256'(in_ready), 256'(1'b1));
    chk("final out_s", 256'({out_s1, out_s2, out_s3}), '0);
    chk("final out_valid", 256'(out_valid), 256'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
